tlb_array: RTL and testbench
============================

Name: tlb_array

Overview:
- Fully associative TLB that answers the address-translation search port driven by the MMU front end.
- Holds the entry storage and services TLBWR/TLBFILL writes, TLBRD reads and INVTLB invalidations from the CSR/execute stage.
- Search and read are combinational; all state updates happen on the clock edge.
- Only page sizes 4 KB (ps=12) and 2 MB (ps=21) are supported.

Parameters:
- TLBNUM, 16, number of entries (power of two).
- IDXW, 4, index width, equal to log2(TLBNUM).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_vppn  in  19  search VA[31:13].
- s_va_bit12  in  1  search VA[12].
- s_asid  in  10  current ASID.
- s_found  out  1  search hit.
- s_index  out  IDXW  index of the hit entry.
- s_ppn  out  20  selected page PPN.
- s_ps  out  6  hit entry page size.
- s_plv  out  2  selected page PLV.
- s_mat  out  2  selected page MAT.
- s_d  out  1  selected page dirty.
- s_v  out  1  selected page valid.
- we  in  1  write enable.
- w_index  in  IDXW  write index.
- w_entry  in  89  entry to write.
- r_index  in  IDXW  read index.
- r_entry  out  89  entry read at r_index.
- invtlb_valid  in  1  invalidate request (one-cycle pulse).
- invtlb_op  in  5  INVTLB op code.
- invtlb_asid  in  10  ASID operand.
- invtlb_vppn  in  19  VA[31:13] operand.
- fill_index  out  IDXW  pseudo-random TLBFILL victim index.

Behaviour:
- Entry packing, used for both w_entry and r_entry:
  - E[88], VPPN[87:69], PS[68:63], G[62], ASID[61:52]
  - PPN0[51:32], PLV0[31:30], MAT0[29:28], D0[27], V0[26]
  - PPN1[25:6], PLV1[5:4], MAT1[3:2], D1[1], V1[0]
- Reset (async, resetn=0):
  - All E bits cleared to 0 and fill_index=0.
  - Other stored fields are not reset.
  - Consequently s_found=0 immediately.
- Search (combinational, zero latency) on entry i: match_i = E & (G | ASID==s_asid) & VPPN compare.
  - VPPN compare for PS=12: VPPN==s_vppn.
  - VPPN compare for PS=21: VPPN[18:9]==s_vppn[18:9].
  - Odd/even page select: s_va_bit12 when PS=12; s_vppn[8] when PS=21. Select=1 picks page 1, else page 0.
- Search outputs:
  - On a hit, s_* outputs come from the selected page of the matching entry.
  - Multiple hits: the lowest index wins.
  - No hit: s_found=0 and all other s_* outputs are 0.
  - s_v is passed through unqualified; the MMU decides the exception.
- Read (combinational): r_entry is entry[r_index] in full, including E and stale fields.
- Write: on the clk edge with we=1, entry[w_index] <= w_entry. Results are visible to search/read from the next cycle.
- INVTLB: on the clk edge with invtlb_valid=1, clear E for every entry satisfying the op:
  - op 0 or 1: all entries.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 & ASID==invtlb_asid.
  - op 5: G=0 & ASID==invtlb_asid & VA match.
  - op 6: (G=1 | ASID==invtlb_asid) & VA match.
  - VA match uses the same PS-aware rule as search, with invtlb_vppn.
  - Op codes 7..31: no state change.
- Simultaneous we and invtlb_valid:
  - Invalidation is evaluated on pre-edge contents.
  - The write to w_index takes priority, so that entry ends with w_entry.
  - All other entries follow the invalidation.
- Same-cycle search during write or invalidate returns pre-edge contents (no bypass).
- fill_index increments by 1 every clock and wraps TLBNUM-1 -> 0. It is free-running and independent of we.
- Reset asserted mid-write or mid-invalidate: reset wins and all E bits end at 0.

Test Plan:
- Reset, then search vppn=0x12345, asid=5 -> s_found=0 and s_ppn=0; fill_index counts 0,1,..,15,0.
- Write idx 3: E=1, VPPN=0x00010, PS=12, G=0, ASID=5, PPN0=0xAAAAA, V0=1, PPN1=0xBBBBB, D1=1. Then:
  - Search vppn=0x00010, bit12=1, asid=5 -> found, s_index=3, s_ppn=0xBBBBB, s_d=1.
  - Same search with bit12=0 -> s_ppn=0xAAAAA.
  - Same search with asid=6 -> s_found=0.
- Write a PS=21 G=1 entry with VPPN=0x3FE00. Search vppn=0x3FF55, asid=9 -> hit. Page select follows vppn[8]=1, so page 1.
- Entries 2 and 7 both match -> s_index=2. Invalidate idx 2 -> s_index=7 the next cycle.
- INVTLB op 4, asid=5 clears only non-global ASID 5 entries and G=1 entries survive; op 2 then clears the G=1 entries; op 9 changes nothing (check via r_entry E bits).
- Same cycle: we to idx 4 plus INVTLB op 0 -> only entry 4 has E=1 afterwards. A same-cycle search still sees the old contents.

Source files
------------

// File: rtl/tlb_array.sv
// -----------------------------------------------------------------------------
// tlb_array - fully associative TLB entry storage with search, read, write,
// INVTLB invalidation and a free-running TLBFILL victim pointer.
//
// Only 4 KB (ps=12) and 2 MB (ps=21) pages are supported. Any PS value other
// than 21 is compared as a 4 KB page.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   s_vppn/s_va_bit12    search VA[31:13] / VA[12]
//   s_asid               current ASID
//   s_found, s_index     hit flag and index of the lowest matching entry
//   s_ppn..s_v           fields of the selected odd/even page (0 on a miss)
//   we/w_index/w_entry   entry write (TLBWR / TLBFILL)
//   r_index/r_entry      combinational entry read (TLBRD)
//   invtlb_*             INVTLB request: op code, ASID and VA operands
//   fill_index           free-running pseudo-random TLBFILL victim index
//
// Entry packing (w_entry / r_entry):
//   E[88] VPPN[87:69] PS[68:63] G[62] ASID[61:52]
//   PPN0[51:32] PLV0[31:30] MAT0[29:28] D0[27] V0[26]
//   PPN1[25:6]  PLV1[5:4]   MAT1[3:2]   D1[1]  V1[0]
// -----------------------------------------------------------------------------
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  // search port
  input  logic [18:0]     s_vppn,
  input  logic            s_va_bit12,
  input  logic [9:0]      s_asid,
  output logic            s_found,
  output logic [IDXW-1:0] s_index,
  output logic [19:0]     s_ppn,
  output logic [5:0]      s_ps,
  output logic [1:0]      s_plv,
  output logic [1:0]      s_mat,
  output logic            s_d,
  output logic            s_v,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [88:0]     w_entry,
  // read port
  input  logic [IDXW-1:0] r_index,
  output logic [88:0]     r_entry,
  // invalidation
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic [9:0]      invtlb_asid,
  input  logic [18:0]     invtlb_vppn,
  // fill victim
  output logic [IDXW-1:0] fill_index
);

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  // Everything in an entry except the E bit; E lives in its own resettable
  // vector so the bulk storage can stay reset-free.
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    page_t       p0;
    page_t       p1;
  } body_t;

  localparam logic [5:0] PS_2M = 6'd21;

  logic [TLBNUM-1:0] e_q;
  body_t             body_q [TLBNUM];
  logic [IDXW-1:0]   fill_q;

  // PS-aware VPPN compare shared by search and INVTLB: a 2 MB page ignores
  // VPPN[8:0] (VPPN[8] then picks the odd/even half instead of VA[12]).
  function automatic logic va_match(input body_t b, input logic [18:0] vppn);
    if (b.ps == PS_2M) return b.vppn[18:9] == vppn[18:9];
    else               return b.vppn == vppn;
  endfunction

  // ---------------------------------------------------------------------------
  // Search
  // ---------------------------------------------------------------------------
  logic [TLBNUM-1:0] s_hit;
  logic              hit_found;
  logic [IDXW-1:0]   hit_idx;
  body_t             hit_body;
  logic              page_sel;
  page_t             hit_page;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      s_hit[i] = e_q[i] && (body_q[i].g || (body_q[i].asid == s_asid))
                 && va_match(body_q[i], s_vppn);
    end
  end

  // Scanning from the top down lets the lowest matching index overwrite any
  // higher one, which gives the lowest-index-wins priority.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s_hit[i]) begin
        hit_found = 1'b1;
        hit_idx   = IDXW'(i);
      end
    end
  end

  assign hit_body = body_q[hit_idx];
  assign page_sel = (hit_body.ps == PS_2M) ? s_vppn[8] : s_va_bit12;
  assign hit_page = page_sel ? hit_body.p1 : hit_body.p0;

  // On a miss every search output is forced to 0 rather than leaking the
  // fields of whatever entry hit_idx happens to point at.
  always_comb begin
    s_found = hit_found;
    s_index = '0;
    s_ppn   = '0;
    s_ps    = '0;
    s_plv   = '0;
    s_mat   = '0;
    s_d     = 1'b0;
    s_v     = 1'b0;
    if (hit_found) begin
      s_index = hit_idx;
      s_ppn   = hit_page.ppn;
      s_ps    = hit_body.ps;
      s_plv   = hit_page.plv;
      s_mat   = hit_page.mat;
      s_d     = hit_page.d;
      s_v     = hit_page.v;   // unqualified: the MMU raises the exception
    end
  end

  // ---------------------------------------------------------------------------
  // Read
  // ---------------------------------------------------------------------------
  assign r_entry = {e_q[r_index], body_q[r_index]};

  // ---------------------------------------------------------------------------
  // INVTLB selection, evaluated on pre-edge contents
  // ---------------------------------------------------------------------------
  logic [TLBNUM-1:0] inv_hit;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      logic asid_eq;
      logic va_eq;
      asid_eq = (body_q[i].asid == invtlb_asid);
      va_eq   = va_match(body_q[i], invtlb_vppn);
      unique case (invtlb_op)
        5'd0, 5'd1: inv_hit[i] = 1'b1;
        5'd2:       inv_hit[i] = body_q[i].g;
        5'd3:       inv_hit[i] = !body_q[i].g;
        5'd4:       inv_hit[i] = !body_q[i].g && asid_eq;
        5'd5:       inv_hit[i] = !body_q[i].g && asid_eq && va_eq;
        5'd6:       inv_hit[i] = (body_q[i].g || asid_eq) && va_eq;
        default:    inv_hit[i] = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // E bits: invalidation first, then the write, so a same-cycle write to
  // w_index overrides any invalidation of that entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the later write
      // below to the same bit simply wins, and readers in other processes see
      // only pre-edge values.
      for (int i = 0; i < TLBNUM; i++) begin
        if (invtlb_valid && inv_hit[i]) e_q[i] <= 1'b0;
      end
      if (we) e_q[w_index] <= w_entry[88];
    end
  end

  // NOTE: the entry storage is deliberately not reset; an entry is only
  // meaningful while its E bit is set, and E is reset above.
  always_ff @(posedge clk) begin
    if (we) body_q[w_index] <= body_t'(w_entry[87:0]);
  end

  // Free-running victim pointer; TLBNUM is a power of two so it wraps
  // naturally at TLBNUM-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fill_q <= '0;
    else         fill_q <= fill_q + IDXW'(1);
  end

  assign fill_index = fill_q;

endmodule

// File: tb/tb_tlb_array.sv
// -----------------------------------------------------------------------------
// tb_tlb_array - directed self-checking bench for tlb_array.
// Inputs change #1 after a rising edge; outputs are compared before the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_tlb_array;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic [18:0]     s_vppn;
  logic            s_va_bit12;
  logic [9:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [19:0]     s_ppn;
  logic [5:0]      s_ps;
  logic [1:0]      s_plv;
  logic [1:0]      s_mat;
  logic            s_d;
  logic            s_v;
  logic            we;
  logic [IDXW-1:0] w_index;
  logic [88:0]     w_entry;
  logic [IDXW-1:0] r_index;
  logic [88:0]     r_entry;
  logic            invtlb_valid;
  logic [4:0]      invtlb_op;
  logic [9:0]      invtlb_asid;
  logic [18:0]     invtlb_vppn;
  logic [IDXW-1:0] fill_index;

  int checks = 0;
  int errors = 0;

  tlb_array #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_vppn(invtlb_vppn),
    .fill_index(fill_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [88:0] got, input logic [88:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_search(input string tag, input logic found, input logic [3:0] idx,
                              input logic [19:0] ppn, input logic [5:0] ps,
                              input logic [1:0] plv, input logic [1:0] mat,
                              input logic d, input logic v);
    check({tag, ".found"}, 89'(s_found), 89'(found));
    check({tag, ".index"}, 89'(s_index), 89'(idx));
    check({tag, ".ppn"},   89'(s_ppn),   89'(ppn));
    check({tag, ".ps"},    89'(s_ps),    89'(ps));
    check({tag, ".plv"},   89'(s_plv),   89'(plv));
    check({tag, ".mat"},   89'(s_mat),   89'(mat));
    check({tag, ".d"},     89'(s_d),     89'(d));
    check({tag, ".v"},     89'(s_v),     89'(v));
  endtask

  function automatic logic [25:0] mk_page(input logic [19:0] ppn, input logic [1:0] plv,
                                          input logic [1:0] mat, input logic d, input logic v);
    return {ppn, plv, mat, d, v};
  endfunction

  function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
                                           input logic [5:0] ps, input logic g,
                                           input logic [9:0] asid,
                                           input logic [25:0] pg0, input logic [25:0] pg1);
    return {e, vppn, ps, g, asid, pg0, pg1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic search(input logic [18:0] vppn, input logic bit12, input logic [9:0] asid);
    s_vppn = vppn; s_va_bit12 = bit12; s_asid = asid;
    #1;
  endtask

  task automatic check_e(input string tag, input int idx, input logic exp);
    r_index = IDXW'(idx);
    #1;
    check($sformatf("%s.e%0d", tag, idx), 89'(r_entry[88]), 89'(exp));
  endtask

  logic [88:0] ent3, ent5, ent4;

  initial begin
    resetn = 1'b0; we = 1'b0; w_index = '0; w_entry = '0; r_index = '0;
    invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0; invtlb_vppn = '0;
    s_vppn = '0; s_va_bit12 = 1'b0; s_asid = '0;

    // ---- reset ------------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    search(19'h12345, 1'b0, 10'd5);
    check_search("reset_miss", 1'b0, 4'd0, 20'h0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("fill%0d", i), 89'(fill_index), 89'(i % 16));
      tick();
    end

    // ---- 4 KB entry at idx 3 (write not visible in the same cycle) --------
    ent3 = mk_entry(1'b1, 19'h00010, 6'd12, 1'b0, 10'd5,
                    mk_page(20'hAAAAA, 2'd0, 2'd0, 1'b0, 1'b1),
                    mk_page(20'hBBBBB, 2'd0, 2'd0, 1'b1, 1'b0));
    we = 1'b1; w_index = 4'd3; w_entry = ent3;
    search(19'h00010, 1'b1, 10'd5);
    check("wr3_same_cycle.found", 89'(s_found), 89'(1'b0));
    tick();
    we = 1'b0;
    search(19'h00010, 1'b1, 10'd5);
    check_search("idx3_odd", 1'b1, 4'd3, 20'hBBBBB, 6'd12, 2'd0, 2'd0, 1'b1, 1'b0);
    search(19'h00010, 1'b0, 10'd5);
    check_search("idx3_even", 1'b1, 4'd3, 20'hAAAAA, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    search(19'h00010, 1'b0, 10'd6);
    check_search("idx3_asid6", 1'b0, 4'd0, 20'h0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    search(19'h00011, 1'b0, 10'd5);
    check("idx3_vppn_off.found", 89'(s_found), 89'(1'b0));
    r_index = 4'd3;
    #1;
    check("rd3", r_entry, ent3);

    // ---- 2 MB global entry at idx 5 ---------------------------------------
    ent5 = mk_entry(1'b1, 19'h3FE00, 6'd21, 1'b1, 10'd1,
                    mk_page(20'h11111, 2'd1, 2'd2, 1'b0, 1'b1),
                    mk_page(20'h22222, 2'd3, 2'd1, 1'b0, 1'b1));
    we = 1'b1; w_index = 4'd5; w_entry = ent5;
    tick();
    we = 1'b0;
    search(19'h3FF55, 1'b0, 10'd9);   // vppn[8]=1 -> page 1, bit12 ignored
    check_search("2m_odd", 1'b1, 4'd5, 20'h22222, 6'd21, 2'd3, 2'd1, 1'b0, 1'b1);
    search(19'h3FE55, 1'b1, 10'd9);   // vppn[8]=0 -> page 0
    check_search("2m_even", 1'b1, 4'd5, 20'h11111, 6'd21, 2'd1, 2'd2, 1'b0, 1'b1);
    search(19'h3FC00, 1'b0, 10'd9);   // vppn[18:9] differs
    check("2m_miss.found", 89'(s_found), 89'(1'b0));

    // ---- multiple hits: entries 7 and 2 ----------------------------------
    we = 1'b1; w_index = 4'd7;
    w_entry = mk_entry(1'b1, 19'h00200, 6'd12, 1'b0, 10'd7,
                       mk_page(20'h77777, 2'd0, 2'd0, 1'b0, 1'b1), 26'h0);
    tick();
    w_index = 4'd2;
    w_entry = mk_entry(1'b1, 19'h00200, 6'd12, 1'b0, 10'd7,
                       mk_page(20'h22220, 2'd0, 2'd0, 1'b0, 1'b1), 26'h0);
    tick();
    we = 1'b0;
    search(19'h00200, 1'b0, 10'd7);
    check_search("multi_hit", 1'b1, 4'd2, 20'h22220, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    we = 1'b1; w_index = 4'd2; w_entry = '0;   // invalidate entry 2
    #1;
    check("inv2_same_cycle.index", 89'(s_index), 89'(4'd2));
    tick();
    we = 1'b0;
    #1;
    check_search("after_inv2", 1'b1, 4'd7, 20'h77777, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);

    // ---- INVTLB ops (valid now: 3 asid5 G0, 5 G1, 7 asid7 G0) -------------
    invtlb_valid = 1'b1; invtlb_op = 5'd4; invtlb_asid = 10'd5;
    tick();
    invtlb_valid = 1'b0;
    check_e("op4", 3, 1'b0);
    check_e("op4", 5, 1'b1);
    check_e("op4", 7, 1'b1);
    invtlb_valid = 1'b1; invtlb_op = 5'd9; invtlb_asid = 10'd7;
    tick();
    invtlb_valid = 1'b0;
    check_e("op9", 5, 1'b1);
    check_e("op9", 7, 1'b1);
    invtlb_valid = 1'b1; invtlb_op = 5'd2;
    tick();
    invtlb_valid = 1'b0;
    check_e("op2", 5, 1'b0);
    check_e("op2", 7, 1'b1);
    // op 5: rewrite idx 3, then clear by ASID 5 + VA; idx 7 (asid 7) survives
    we = 1'b1; w_index = 4'd3; w_entry = ent3;
    tick();
    we = 1'b0;
    invtlb_valid = 1'b1; invtlb_op = 5'd5; invtlb_asid = 10'd5; invtlb_vppn = 19'h00010;
    tick();
    invtlb_valid = 1'b0;
    check_e("op5", 3, 1'b0);
    check_e("op5", 7, 1'b1);

    // ---- simultaneous write to idx 4 and INVTLB op 0 ----------------------
    ent4 = mk_entry(1'b1, 19'h00400, 6'd12, 1'b0, 10'd2,
                    mk_page(20'h44444, 2'd2, 2'd1, 1'b1, 1'b1), 26'h0);
    we = 1'b1; w_index = 4'd4; w_entry = ent4;
    invtlb_valid = 1'b1; invtlb_op = 5'd0;
    search(19'h00200, 1'b0, 10'd7);
    check("wr_inv_same_cycle.index", 89'(s_index), 89'(4'd7));
    tick();
    we = 1'b0; invtlb_valid = 1'b0;
    for (int i = 0; i < TLBNUM; i++) check_e("wr_inv", i, (i == 4));
    search(19'h00200, 1'b0, 10'd7);
    check("wr_inv_old.found", 89'(s_found), 89'(1'b0));
    search(19'h00400, 1'b0, 10'd2);
    check_search("wr_inv_new", 1'b1, 4'd4, 20'h44444, 6'd12, 2'd2, 2'd1, 1'b1, 1'b1);

    // ---- reset asserted during a write -----------------------------------
    we = 1'b1; w_index = 4'd6;
    w_entry = mk_entry(1'b1, 19'h00600, 6'd12, 1'b1, 10'd0, 26'h0, 26'h0);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_mid.found", 89'(s_found), 89'(1'b0));
    check("rst_mid.fill", 89'(fill_index), 89'(0));
    tick();
    check_e("rst_mid", 6, 1'b0);
    check_e("rst_mid", 4, 1'b0);
    we = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_e("post_rst", 6, 1'b0);
    check("post_rst.fill", 89'(fill_index), 89'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
